// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered frame feeder for the LED-matrix scanner.
// Define FRAME_SCROLL_EN to rotate the front buffer one column left every SCROLL_DIV frames.
module frame_sequencer #(
    parameter int GS         = 8,
    parameter int SCROLL_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [$clog2(GS)-1:0] wr_row_i,
    input  logic [$clog2(GS)-1:0] wr_col_i,
    input  logic                  wr_data_i,
    input  logic                  clr_i,
    input  logic                  swap_i,
    output logic                  swap_done_o,
    input  logic                  run_i,
    output logic [GS*GS-1:0]      matrix_o,
    output logic                  e_disp_o,
    input  logic                  d_disp_i,
    output logic [15:0]           frame_cnt_o
);
    localparam int NB = GS * GS;
    localparam int IW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, START, WAIT, SWAP} state_t;

    if (GS < 2) begin : gBadGs
        $error("frame_sequencer: GS must be at least 2");
    end
    if (SCROLL_DIV < 1) begin : gBadDiv
        $error("frame_sequencer: SCROLL_DIV must be at least 1");
    end

    state_t        state_q, state_d;
    logic          eDisp_q, eDisp_d;
    logic          swapDone_q, swapDone_d;
    logic          swapPend_q, swapPend_d;
    logic [15:0]   frameCnt_q, frameCnt_d;
    logic [NB-1:0] back_q, back_d;
    logic [NB-1:0] front_q, front_d;
    logic [IW-1:0] wrIdx;
    logic          wrInRange;
    logic          frameDone;

    assign frameDone   = (state_q == WAIT) && d_disp_i;
    assign wr_ready_o  = !rst_i && (state_q != SWAP);
    assign swap_done_o = swapDone_q;
    assign e_disp_o    = eDisp_q;
    assign matrix_o    = front_q;
    assign frame_cnt_o = frameCnt_q;

    assign wrInRange = (int'(wr_row_i) < GS) && (int'(wr_col_i) < GS);
    assign wrIdx     = IW'(wr_row_i) * IW'(GS) + IW'(wr_col_i);

    // Out-of-range coordinates are still handshaken, they just never touch the buffer.
    always_comb begin
        back_d = back_q;
        if (clr_i) begin
            back_d = '0;
        end else if (wr_valid_i && wr_ready_o && wrInRange) begin
            back_d[wrIdx] = wr_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (swapPend_q) begin
                    state_d = SWAP;
                end else if (run_i) begin
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (d_disp_i) begin
                    if (swapPend_q) begin
                        state_d = SWAP;
                    end else if (run_i) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SWAP:    state_d = run_i ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FRAME_SCROLL_EN
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [NB-1:0] frontRot;

    for (genvar r = 0; r < GS; r++) begin : gRot
        assign frontRot[r*GS +: GS] = {front_q[r*GS], front_q[r*GS+GS-1 : r*GS+1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`endif

    always_comb begin
        eDisp_d    = (state_d == WAIT);
        swapDone_d = (state_d == SWAP);
        swapPend_d = swap_i || (swapPend_q && (state_q != SWAP));
        frameCnt_d = frameDone ? frameCnt_q + 16'd1 : frameCnt_q;
        front_d    = (state_q == SWAP) ? back_q : front_q;
`ifdef FRAME_SCROLL_EN
        // A pending swap overrides the scroll step; SWAP then restarts the divider.
        div_d = div_q;
        if (state_q == SWAP) begin
            div_d = '0;
        end else if (frameDone && !swapPend_q) begin
            if (div_q == DW'(SCROLL_DIV - 1)) begin
                div_d   = '0;
                front_d = frontRot;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            eDisp_q    <= 1'b0;
            swapDone_q <= 1'b0;
            swapPend_q <= 1'b0;
            frameCnt_q <= '0;
            back_q     <= '0;
            front_q    <= '0;
        end else begin
            state_q    <= state_d;
            eDisp_q    <= eDisp_d;
            swapDone_q <= swapDone_d;
            swapPend_q <= swapPend_d;
            frameCnt_q <= frameCnt_d;
            back_q     <= back_d;
            front_q    <= front_d;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus random traffic against a behavioural model.
// Honours FRAME_SCROLL_EN the same way the design does.
module tb_frame_sequencer;
    localparam int GS     = 8;
    localparam int NB     = GS * GS;
    localparam int SDIV   = 2;
    localparam int GS6    = 6;
    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_SCAN = 2;
    localparam int P_COPY = 3;
    localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wrValid, wrData, clr, swap, run, dDisp;
    logic [2:0]    wrRow, wrCol;
    logic          wrReady, swapDone, eDisp;
    logic [NB-1:0] matrix;
    logic [15:0]   frameCnt;

    logic                 wrValid6, wrData6, swap6;
    logic [2:0]           wrRow6, wrCol6;
    logic                 wrReady6, swapDone6, eDisp6;
    logic [GS6*GS6-1:0]   matrix6;
    logic [15:0]          frameCnt6;

    frame_sequencer #(.GS(GS), .SCROLL_DIV(SDIV)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wrValid), .wr_ready_o(wrReady),
        .wr_row_i(wrRow), .wr_col_i(wrCol), .wr_data_i(wrData),
        .clr_i(clr), .swap_i(swap), .swap_done_o(swapDone),
        .run_i(run), .matrix_o(matrix),
        .e_disp_o(eDisp), .d_disp_i(dDisp), .frame_cnt_o(frameCnt)
    );

    frame_sequencer #(.GS(GS6), .SCROLL_DIV(SDIV)) dut6 (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wrValid6), .wr_ready_o(wrReady6),
        .wr_row_i(wrRow6), .wr_col_i(wrCol6), .wr_data_i(wrData6),
        .clr_i(1'b0), .swap_i(swap6), .swap_done_o(swapDone6),
        .run_i(1'b0), .matrix_o(matrix6),
        .e_disp_o(eDisp6), .d_disp_i(1'b0), .frame_cnt_o(frameCnt6)
    );

    int checks = 0;
    int errors = 0;
    int scanMode = 0;
    int hiCnt = 0;
    int rows6[5] = '{7, 6, 0, 0, 1};
    int cols6[5] = '{0, 0, 6, 7, 1};

    // Reference model: pixel grids plus the scanner handshake phase.
    bit          mBack[GS][GS];
    bit          mFront[GS][GS];
    int          mPhase;
    bit          mPend;
    logic [15:0] mCnt;
`ifdef FRAME_SCROLL_EN
    int          mDiv;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < GS; r++) begin
            for (int c = 0; c < GS; c++) begin
                mBack[r][c]  = 1'b0;
                mFront[r][c] = 1'b0;
            end
        end
        mPhase = P_IDLE;
        mPend  = 1'b0;
        mCnt   = '0;
`ifdef FRAME_SCROLL_EN
        mDiv   = 0;
`endif
    endtask

    task automatic modelStep();
        bit snap[GS][GS];
        bit done;
        bit ready;
        int nxt;
`ifdef FRAME_SCROLL_EN
        bit tmp[GS][GS];
`endif
        if (rst) begin
            modelReset();
            return;
        end
        ready = (mPhase != P_COPY);
        done  = (mPhase == P_SCAN) && dDisp;
        snap  = mBack;
        case (mPhase)
            P_IDLE:  nxt = mPend ? P_COPY : (run ? P_ARM : P_IDLE);
            P_ARM:   nxt = P_SCAN;
            P_SCAN:  nxt = !dDisp ? P_SCAN : (mPend ? P_COPY : (run ? P_ARM : P_IDLE));
            default: nxt = run ? P_ARM : P_IDLE;
        endcase
        if (mPhase == P_COPY) mFront = snap;
`ifdef FRAME_SCROLL_EN
        if (mPhase == P_COPY) begin
            mDiv = 0;
        end else if (done && !mPend) begin
            mDiv++;
            if (mDiv == SDIV) begin
                mDiv = 0;
                for (int r = 0; r < GS; r++)
                    for (int c = 0; c < GS; c++)
                        tmp[r][c] = mFront[r][(c + 1) % GS];
                mFront = tmp;
            end
        end
`endif
        if (clr) begin
            for (int r = 0; r < GS; r++)
                for (int c = 0; c < GS; c++)
                    mBack[r][c] = 1'b0;
        end else if (wrValid && ready && int'(wrRow) < GS && int'(wrCol) < GS) begin
            mBack[wrRow][wrCol] = wrData;
        end
        mPend = swap || (mPend && mPhase != P_COPY);
        if (done) mCnt = mCnt + 16'd1;
        mPhase = nxt;
    endtask

    function automatic logic [NB-1:0] packFront();
        logic [NB-1:0] v;
        v = '0;
        for (int r = 0; r < GS; r++)
            for (int c = 0; c < GS; c++)
                v[r*GS + c] = mFront[r][c];
        return v;
    endfunction

    task automatic checkOutput();
        check("e_disp_o", 64'(eDisp), 64'(mPhase == P_SCAN));
        check("swap_done_o", 64'(swapDone), 64'(mPhase == P_COPY));
        check("wr_ready_o", 64'(wrReady), 64'(!rst && mPhase != P_COPY));
        check("matrix_o", 64'(matrix), 64'(packFront()));
        check("frame_cnt_o", 64'(frameCnt), 64'(mCnt));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge,
    // then the scanner stand-in decides d_disp for the next edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
        if (scanMode == 1) begin
            hiCnt = eDisp ? hiCnt + 1 : 0;
            dDisp = (hiCnt >= 20);
        end else begin
            dDisp = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic waitSwapDone(input int limit);
        int n = 0;
        while (swapDone !== 1'b1 && n < limit) begin
            applyStimulus();
            n++;
        end
        check("swap_done_seen", 64'(swapDone), 64'd1);
    endtask

    task automatic waitEnable(input int limit);
        int n = 0;
        while (eDisp !== 1'b1 && n < limit) begin
            applyStimulus();
            n++;
        end
        check("enable_seen", 64'(eDisp), 64'd1);
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (mPhase != P_IDLE && n < limit) begin
            applyStimulus();
            n++;
        end
        check("idle_reached", 64'(eDisp), 64'd0);
    endtask

    task automatic waitFrames(input logic [15:0] target, input int limit);
        int n = 0;
        while (mCnt != target && n < limit) begin
            applyStimulus();
            n++;
        end
        check("frames_reached", 64'(frameCnt), 64'(target));
    endtask

    initial begin
        int n;
        int rises;
        logic prevE;
        logic [15:0] base;

        rst = 1'b1; wrValid = 1'b0; wrData = 1'b0; wrRow = '0; wrCol = '0;
        clr = 1'b0; swap = 1'b0; run = 1'b0; dDisp = 1'b0;
        wrValid6 = 1'b0; wrData6 = 1'b0; wrRow6 = '0; wrCol6 = '0; swap6 = 1'b0;
        modelReset();

        repeat (3) applyStimulus();
        check("ready_in_reset", 64'(wrReady), 64'd0);
        rst = 1'b0;
        applyStimulus();
        check("ready_after_reset", 64'(wrReady), 64'd1);
        check("matrix_after_reset", 64'(matrix), 64'd0);
        check("cnt_after_reset", 64'(frameCnt), 64'd0);

        // Diagonal pattern, swap while stopped.
        for (int i = 0; i < GS; i++) begin
            wrValid = 1'b1; wrRow = 3'(i); wrCol = 3'(i); wrData = 1'b1;
            applyStimulus();
        end
        wrValid = 1'b0; swap = 1'b1;
        applyStimulus();
        swap = 1'b0;
        waitSwapDone(10);
        check("ready_in_swap", 64'(wrReady), 64'd0);
        applyStimulus();
        check("diag_matrix", 64'(matrix), DIAG);
        check("diag_no_enable", 64'(eDisp), 64'd0);

        // Three frames with a 20-cycle scanner, run dropped during the third.
        scanMode = 1; hiCnt = 0; run = 1'b1; rises = 0; prevE = 1'b0; n = 0;
        while (mCnt < 3 && n < 300) begin
            if (mCnt == 2) run = 1'b0;
            applyStimulus();
            n++;
            if (eDisp && !prevE) rises++;
            prevE = eDisp;
        end
        applyStimulus();
        check("frames_done", 64'(frameCnt), 64'd3);
        check("frames_started", 64'(rises), 64'd3);
        check("idle_after_stop", 64'(eDisp), 64'd0);

        // Swap and write requested mid-frame; front must hold until the frame ends.
        run = 1'b1; hiCnt = 0;
        waitEnable(20);
        wrValid = 1'b1; wrRow = 3'd3; wrCol = 3'd5; wrData = 1'b1; swap = 1'b1;
        applyStimulus();
        wrValid = 1'b0; swap = 1'b0; n = 0;
        while (eDisp && n < 100) begin
            check("matrix_held", 64'(matrix), DIAG);
            applyStimulus();
            n++;
        end
        waitSwapDone(10);
        check("ready_in_swap2", 64'(wrReady), 64'd0);
        wrValid = 1'b1; wrRow = 3'd4; wrCol = 3'd4; wrData = 1'b0;
        applyStimulus();
        wrValid = 1'b0; run = 1'b0;
        check("matrix_swapped", 64'(matrix), DIAG | (64'd1 << 29));
        waitIdle(100);

        // Clear beats a simultaneous write.
        scanMode = 0;
        clr = 1'b1; wrValid = 1'b1; wrRow = 3'd0; wrCol = 3'd0; wrData = 1'b1;
        applyStimulus();
        clr = 1'b0; wrValid = 1'b0; swap = 1'b1;
        applyStimulus();
        swap = 1'b0;
        waitSwapDone(10);
        applyStimulus();
        check("clear_wins", 64'(matrix), 64'd0);

        // Non-power-of-two edge: rows/cols 6 and 7 are discarded.
        check("gs6_ready", 64'(wrReady6), 64'd1);
        for (int i = 0; i < 5; i++) begin
            wrValid6 = 1'b1; wrRow6 = 3'(rows6[i]); wrCol6 = 3'(cols6[i]); wrData6 = 1'b1;
            applyStimulus();
        end
        wrValid6 = 1'b0; swap6 = 1'b1;
        applyStimulus();
        swap6 = 1'b0; n = 0;
        while (swapDone6 !== 1'b1 && n < 10) begin
            applyStimulus();
            n++;
        end
        check("gs6_swap_done", 64'(swapDone6), 64'd1);
        applyStimulus();
        check("gs6_out_of_range", 64'(matrix6), 64'h80);
        check("gs6_idle", 64'(eDisp6), 64'd0);
        check("gs6_cnt", 64'(frameCnt6), 64'd0);

        // Single pixel at (0,0) then four frames of scrolling.
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0; wrValid = 1'b1; wrRow = 3'd0; wrCol = 3'd0; wrData = 1'b1;
        applyStimulus();
        wrValid = 1'b0; swap = 1'b1;
        applyStimulus();
        swap = 1'b0;
        waitSwapDone(10);
        applyStimulus();
        check("scroll_seed", 64'(matrix), 64'h1);
        base = mCnt; scanMode = 1; hiCnt = 0; run = 1'b1;
        waitFrames(base + 16'd2, 100);
`ifdef FRAME_SCROLL_EN
        check("scroll_2", 64'(matrix), 64'h80);
`else
        check("scroll_2", 64'(matrix), 64'h1);
`endif
        waitFrames(base + 16'd4, 100);
`ifdef FRAME_SCROLL_EN
        check("scroll_4", 64'(matrix), 64'h40);
`else
        check("scroll_4", 64'(matrix), 64'h1);
`endif

        // Reset in the middle of a frame takes effect without a clock.
        waitEnable(20);
        applyStimulus();
        rst = 1'b1;
        #1;
        check("rst_e_disp", 64'(eDisp), 64'd0);
        check("rst_matrix", 64'(matrix), 64'd0);
        check("rst_cnt", 64'(frameCnt), 64'd0);
        check("rst_ready", 64'(wrReady), 64'd0);
        check("rst_swap_done", 64'(swapDone), 64'd0);
        run = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // Random traffic with a random scanner.
        scanMode = 0;
        for (int k = 0; k < 2500; k++) begin
            wrValid = ($urandom_range(0, 1) == 1);
            wrRow   = 3'($urandom_range(0, 7));
            wrCol   = 3'($urandom_range(0, 7));
            wrData  = ($urandom_range(0, 1) == 1);
            clr     = ($urandom_range(0, 15) == 0);
            swap    = ($urandom_range(0, 7) == 0);
            run     = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        rst = 1'b0; wrValid = 1'b0; clr = 1'b0; swap = 1'b0; run = 1'b0;
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
